// File: rtl/eprom_page_programmer.sv
// eprom_page_programmer: host-driven EPROM page programming engine.
// Receives 'P' ADDR_HI ADDR_LO LEN DATA... from the UART, buffers one page,
// then programs each byte with a Vpp-sequenced pulse and replies ACK/NAK.
// Optional read-back verify with retries: define VERIFY_EN.
module eprom_page_programmer #(
  parameter int ADDR_W         = 11,
  parameter int PAGE_DEPTH     = 64,
  parameter int VPP_SETTLE_CYC = 5000,
  parameter int SETUP_CYC      = 100,
  parameter int PULSE_CYC      = 2500000,
  parameter int HOLD_CYC       = 100,
  parameter int RX_TIMEOUT_CYC = 50000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] ep_addr,
  output logic [7:0]        ep_dout,
  input  logic [7:0]        ep_din,
  output logic              ep_data_oe,
  output logic              ep_oe_n,
  output logic              prog_ce,
  output logic              vpp_en,
  output logic              vcc5_en,
  output logic              busy,
  output logic              err
);
  localparam int IDX_W = (PAGE_DEPTH > 1) ? $clog2(PAGE_DEPTH) : 1;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE, S_A_HI, S_A_LO, S_LEN, S_LOAD, S_VPP_ON, S_SETUP,
    S_PULSE, S_HOLD, S_VERIFY, S_VPP_OFF, S_RESP, S_RESP2
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       cnt_reg, to_cnt_reg;
  logic [15:0]       base_reg;
  logic [7:0]        len_reg, idx_reg, idx_next;
  logic              nak_reg, err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        dout_reg;
  logic [7:0]        mem [PAGE_DEPTH];

  logic timer_done, rx_expired, last_byte, len_bad;
  logic byte_ok, retry_ok, resp_second, resp_nak;
  logic [7:0] resp2_byte;

  assign timer_done = (cnt_reg == 32'd0);
  assign rx_expired = (to_cnt_reg == 32'd0);
  assign last_byte  = (idx_reg == len_reg);
  assign len_bad    = ({1'b0, rx_data} >= 9'(PAGE_DEPTH));
  assign resp_nak   = nak_reg | resp_second;

`ifdef VERIFY_EN
  logic [7:0] retry_reg, fail_addr_reg;
  logic       vfail_reg;
  assign byte_ok     = (ep_din == dout_reg);
  assign retry_ok    = (retry_reg < 8'(MAX_RETRY));
  assign resp_second = vfail_reg;
  assign resp2_byte  = fail_addr_reg;

  // Retry counting and capture of the address that finally failed verify
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_reg     <= '0;
      fail_addr_reg <= '0;
      vfail_reg     <= 1'b0;
    end else begin
      if (state_reg == S_VPP_ON)
        retry_reg <= '0;
      else if (state_reg == S_VERIFY && timer_done)
        retry_reg <= byte_ok ? 8'd0 : retry_reg + 8'd1;
      if (state_reg == S_IDLE)
        vfail_reg <= 1'b0;
      else if (state_reg == S_VERIFY && timer_done && !byte_ok && !retry_ok) begin
        vfail_reg     <= 1'b1;
        fail_addr_reg <= addr_reg[7:0];
      end
    end
  end
`else
  logic unused_verify;
  assign unused_verify = ^{ep_din, 32'(MAX_RETRY)};
  assign byte_ok       = 1'b1;
  assign retry_ok      = 1'b0;
  assign resp_second   = 1'b0;
  assign resp2_byte    = 8'h00;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (rx_valid) state_next = (rx_data == CMD_P) ? S_A_HI : S_RESP;
      S_A_HI:    if (rx_valid) state_next = S_A_LO; else if (rx_expired) state_next = S_RESP;
      S_A_LO:    if (rx_valid) state_next = S_LEN;  else if (rx_expired) state_next = S_RESP;
      S_LEN:     if (rx_valid) state_next = len_bad ? S_RESP : S_LOAD;
                 else if (rx_expired) state_next = S_RESP;
      S_LOAD:    if (rx_valid) begin
                   if (last_byte) state_next = S_VPP_ON;
                 end else if (rx_expired) state_next = S_RESP;
      S_VPP_ON:  if (timer_done) state_next = S_SETUP;
      S_SETUP:   if (timer_done) state_next = S_PULSE;
      S_PULSE:   if (timer_done) state_next = S_HOLD;
      S_HOLD:    if (timer_done) begin
`ifdef VERIFY_EN
                   state_next = S_VERIFY;
`else
                   state_next = last_byte ? S_VPP_OFF : S_SETUP;
`endif
                 end
      S_VERIFY:  if (timer_done) begin
                   if (byte_ok)       state_next = last_byte ? S_VPP_OFF : S_SETUP;
                   else if (retry_ok) state_next = S_SETUP;
                   else               state_next = S_VPP_OFF;
                 end
      S_VPP_OFF: state_next = S_RESP;
      S_RESP:    if (!tx_busy) state_next = resp_second ? S_RESP2 : S_IDLE;
      S_RESP2:   if (!tx_busy) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Byte index: counts received bytes while loading, then the byte being programmed
  always_comb begin
    idx_next = idx_reg;
    case (state_reg)
      S_IDLE:           idx_next = 8'd0;
      S_LOAD:           if (rx_valid) idx_next = last_byte ? 8'd0 : idx_reg + 8'd1;
      S_HOLD, S_VERIFY: if (state_next == S_SETUP && byte_ok) idx_next = idx_reg + 8'd1;
      default:          idx_next = idx_reg;
    endcase
  end

  // Page buffer write port
  always_ff @(posedge clk) begin
    if (state_reg == S_LOAD && rx_valid) mem[idx_reg[IDX_W-1:0]] <= rx_data;
  end

  // Datapath: timers, command fields, registered address/data to the socket
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      to_cnt_reg <= '0;
      base_reg   <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      nak_reg    <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      dout_reg   <= '0;
    end else begin
      idx_reg <= idx_next;
      // addr/data follow idx_next so they change on the same edge as the byte index
      addr_reg <= base_reg[ADDR_W-1:0] + ADDR_W'(idx_next);
      dout_reg <= mem[idx_next[IDX_W-1:0]];

      if (state_next != state_reg) begin
        case (state_next)
          S_VPP_ON: cnt_reg <= 32'(VPP_SETTLE_CYC - 1);
          S_SETUP:  cnt_reg <= 32'(SETUP_CYC - 1);
          S_PULSE:  cnt_reg <= 32'(PULSE_CYC - 1);
          S_HOLD:   cnt_reg <= 32'(HOLD_CYC - 1);
          S_VERIFY: cnt_reg <= 32'd5;
          default:  cnt_reg <= 32'd0;
        endcase
      end else if (cnt_reg != 32'd0) begin
        cnt_reg <= cnt_reg - 32'd1;
      end

      if (rx_valid)                 to_cnt_reg <= 32'(RX_TIMEOUT_CYC - 1);
      else if (to_cnt_reg != 32'd0) to_cnt_reg <= to_cnt_reg - 32'd1;

      if (state_reg == S_A_HI && rx_valid) base_reg[15:8] <= rx_data;
      if (state_reg == S_A_LO && rx_valid) base_reg[7:0]  <= rx_data;
      if (state_reg == S_LEN  && rx_valid) len_reg        <= rx_data;

      if (state_reg == S_IDLE && rx_valid)
        nak_reg <= (rx_data != CMD_P);
      else if (state_next == S_RESP && state_reg inside {S_A_HI, S_A_LO, S_LEN, S_LOAD})
        nak_reg <= 1'b1;

      if (state_reg == S_IDLE && rx_valid && rx_data == CMD_P)
        err_reg <= 1'b0;
      else if (state_reg == S_RESP && !tx_busy && resp_nak)
        err_reg <= 1'b1;
    end
  end

  // Output decode from state
  always_comb begin
    busy       = (state_reg != S_IDLE);
    prog_ce    = (state_reg == S_PULSE);
    vpp_en     = state_reg inside {S_VPP_ON, S_SETUP, S_PULSE, S_HOLD, S_VERIFY};
    ep_data_oe = state_reg inside {S_VPP_ON, S_SETUP, S_PULSE, S_HOLD};
    ep_oe_n    = !(state_reg == S_VERIFY && cnt_reg <= 32'd1);
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    if (!tx_busy && state_reg == S_RESP) begin
      tx_valid = 1'b1;
      tx_data  = resp_nak ? NAK : ACK;
    end else if (!tx_busy && state_reg == S_RESP2) begin
      tx_valid = 1'b1;
      tx_data  = resp2_byte;
    end
  end

  assign vcc5_en = ~vpp_en;
  assign ep_addr = addr_reg;
  assign ep_dout = dout_reg;
  assign err     = err_reg;
endmodule

// File: tb/tb_eprom_page_programmer.sv
// Testbench for eprom_page_programmer: table of command vectors plus
// hand-written sequences for timeout, tx back-pressure, reset mid-pulse
// and (with VERIFY_EN) verify failure.
module tb_eprom_page_programmer;
  localparam int PULSE = 10;
`ifdef VERIFY_EN
  localparam int SPACING = 20;
`else
  localparam int SPACING = 14;
`endif
  localparam int SETTLE_TO_PULSE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rx_valid, tx_valid, tx_busy;
  logic [7:0]  rx_data, tx_data, ep_dout, ep_din;
  logic [10:0] ep_addr;
  logic        ep_data_oe, ep_oe_n, prog_ce, vpp_en, vcc5_en, busy, err;
  logic        din_stuck;

  assign ep_din = din_stuck ? 8'hFF : ep_dout;

  eprom_page_programmer #(
    .ADDR_W(11), .PAGE_DEPTH(4), .VPP_SETTLE_CYC(5), .SETUP_CYC(2),
    .PULSE_CYC(PULSE), .HOLD_CYC(2), .RX_TIMEOUT_CYC(100), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .ep_addr(ep_addr), .ep_dout(ep_dout), .ep_din(ep_din),
    .ep_data_oe(ep_data_oe), .ep_oe_n(ep_oe_n), .prog_ce(prog_ce),
    .vpp_en(vpp_en), .vcc5_en(vcc5_en), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: records pulses, Vpp rises and transmitted bytes
  int          cyc = 0, pulse_n = 0, cur_len = 0, vpp_rise = 0, vpp_cnt = 0;
  int          stab_bad = 0, vcc_bad = 0, txbusy_bad = 0;
  logic        prev_ce = 1'b0, prev_vpp = 1'b0;
  logic [10:0] p_addr [64];
  logic [7:0]  p_dout [64];
  int          p_len [64];
  int          p_start [64];
  logic [7:0]  tx_q [$];

  always @(negedge clk) begin
    cyc++;
    if (prog_ce) begin
      if (!prev_ce) begin
        if (pulse_n < 64) begin
          p_addr[pulse_n]  = ep_addr;
          p_dout[pulse_n]  = ep_dout;
          p_start[pulse_n] = cyc;
        end
        cur_len = 0;
      end
      cur_len++;
      if (pulse_n < 64 && (ep_addr !== p_addr[pulse_n] || ep_dout !== p_dout[pulse_n] || ep_data_oe !== 1'b1))
        stab_bad++;
    end else if (prev_ce) begin
      if (pulse_n < 64) p_len[pulse_n] = cur_len;
      pulse_n++;
    end
    prev_ce = prog_ce;
    if (vpp_en && !prev_vpp) begin
      vpp_rise = cyc;
      vpp_cnt++;
    end
    prev_vpp = vpp_en;
    if (vcc5_en === vpp_en) vcc_bad++;
    if (tx_valid && tx_busy) txbusy_bad++;
    if (tx_valid) tx_q.push_back(tx_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string name);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tx_q.size() < n) begin
      errors++;
      $display("FAIL %s: response timeout, got %0d tx bytes expected %0d", name, tx_q.size(), n);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [0:7][7:0]  bytes;
    int               nbytes;
    logic [7:0]       resp;
    int               npulse;
    logic [0:3][10:0] addr;
    logic [0:3][7:0]  dout;
    logic             exp_err;
  } vec_t;

  vec_t vecs [6];
  int   p0, t0, vc0, k;

  initial begin
    vecs[0] = '{bytes: {8'h50, 8'h01, 8'h23, 8'h01, 8'hAA, 8'h55, 8'h00, 8'h00}, nbytes: 6, resp: 8'h06,
                npulse: 2, addr: {11'h123, 11'h124, 11'h000, 11'h000}, dout: {8'hAA, 8'h55, 8'h00, 8'h00}, exp_err: 1'b0};
    vecs[1] = '{bytes: {8'h50, 8'h07, 8'hFF, 8'h01, 8'h11, 8'h22, 8'h00, 8'h00}, nbytes: 6, resp: 8'h06,
                npulse: 2, addr: {11'h7FF, 11'h000, 11'h000, 11'h000}, dout: {8'h11, 8'h22, 8'h00, 8'h00}, exp_err: 1'b0};
    vecs[2] = '{bytes: {8'h50, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 4, resp: 8'h15,
                npulse: 0, addr: {11'h000, 11'h000, 11'h000, 11'h000}, dout: {8'h00, 8'h00, 8'h00, 8'h00}, exp_err: 1'b1};
    vecs[3] = '{bytes: {8'h50, 8'h00, 8'h12, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00}, nbytes: 5, resp: 8'h06,
                npulse: 1, addr: {11'h012, 11'h000, 11'h000, 11'h000}, dout: {8'h5A, 8'h00, 8'h00, 8'h00}, exp_err: 1'b0};
    vecs[4] = '{bytes: {8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nbytes: 1, resp: 8'h15,
                npulse: 0, addr: {11'h000, 11'h000, 11'h000, 11'h000}, dout: {8'h00, 8'h00, 8'h00, 8'h00}, exp_err: 1'b1};
    vecs[5] = '{bytes: {8'h50, 8'h00, 8'h20, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04}, nbytes: 8, resp: 8'h06,
                npulse: 4, addr: {11'h020, 11'h021, 11'h022, 11'h023}, dout: {8'h01, 8'h02, 8'h03, 8'h04}, exp_err: 1'b0};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; din_stuck = 1'b0;
    repeat (2) @(negedge clk);
    check("rst tx_data", tx_data, 0);
    check("rst tx_valid", tx_valid, 0);
    check("rst ep_addr", ep_addr, 0);
    check("rst ep_dout", ep_dout, 0);
    check("rst ep_data_oe", ep_data_oe, 0);
    check("rst ep_oe_n", ep_oe_n, 1);
    check("rst prog_ce", prog_ce, 0);
    check("rst vpp_en", vpp_en, 0);
    check("rst vcc5_en", vcc5_en, 1);
    check("rst busy", busy, 0);
    check("rst err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      p0 = pulse_n; t0 = tx_q.size(); vc0 = vpp_cnt;
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        send_byte(vecs[v].bytes[b]);
        if (b == 0 && vecs[v].bytes[0] == 8'h50) check($sformatf("v%0d err cleared by P", v), err, 0);
      end
      check($sformatf("v%0d vpp 1 cycle after last byte", v), vpp_en, vecs[v].npulse > 0);
      wait_tx(t0 + 1, $sformatf("v%0d", v));
      check($sformatf("v%0d response", v), tx_q[t0], vecs[v].resp);
      check($sformatf("v%0d tx count", v), tx_q.size(), t0 + 1);
      check($sformatf("v%0d pulse count", v), pulse_n - p0, vecs[v].npulse);
      for (int q = 0; q < vecs[v].npulse; q++) begin
        check($sformatf("v%0d p%0d addr", v, q), p_addr[p0 + q], vecs[v].addr[q]);
        check($sformatf("v%0d p%0d dout", v, q), p_dout[p0 + q], vecs[v].dout[q]);
        check($sformatf("v%0d p%0d width", v, q), p_len[p0 + q], PULSE);
        if (q > 0) check($sformatf("v%0d p%0d spacing", v, q), p_start[p0 + q] - p_start[p0 + q - 1], SPACING);
      end
      if (vecs[v].npulse > 0) check($sformatf("v%0d settle+setup", v), p_start[p0] - vpp_rise, SETTLE_TO_PULSE);
      check($sformatf("v%0d vpp raised", v), vpp_cnt - vc0, vecs[v].npulse > 0);
      check($sformatf("v%0d err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d busy idle", v), busy, 0);
    end

    // Receive timeout mid-payload
    t0 = tx_q.size(); vc0 = vpp_cnt;
    send_byte(8'h50); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03); send_byte(8'h01);
    repeat (90) @(negedge clk);
    check("timeout not early", tx_q.size(), t0);
    check("timeout busy while waiting", busy, 1);
    wait_tx(t0 + 1, "timeout");
    check("timeout NAK", tx_q[t0], 8'h15);
    check("timeout no vpp", vpp_cnt - vc0, 0);
    check("timeout err", err, 1);

    // tx back-pressure, stray byte during programming is dropped
    t0 = tx_q.size(); p0 = pulse_n;
    tx_busy = 1'b1;
    send_byte(8'h50); send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h3C);
    repeat (8) @(negedge clk);
    send_byte(8'h41);
    repeat (60) @(negedge clk);
    check("txbusy holds response", tx_q.size(), t0);
    check("txbusy still busy", busy, 1);
    tx_busy = 1'b0;
    wait_tx(t0 + 1, "txbusy");
    repeat (20) @(negedge clk);
    check("txbusy ACK", tx_q[t0], 8'h06);
    check("txbusy single response", tx_q.size(), t0 + 1);
    check("txbusy pulse count", pulse_n - p0, 1);
    check("txbusy addr", p_addr[p0], 11'h200);
    check("txbusy dout", p_dout[p0], 8'h3C);

    // Reset asserted during a program pulse
    t0 = tx_q.size();
    send_byte(8'h50); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h77);
    k = 0;
    while (!prog_ce && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rstpulse reached pulse", prog_ce, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstpulse prog_ce", prog_ce, 0);
    check("rstpulse vpp_en", vpp_en, 0);
    check("rstpulse vcc5_en", vcc5_en, 1);
    check("rstpulse busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rstpulse idle busy", busy, 0);
    check("rstpulse idle vpp", vpp_en, 0);
    check("rstpulse no tx", tx_q.size(), t0);

`ifdef VERIFY_EN
    // Verify failure: socket reads back 0xFF for a 0x00 byte
    t0 = tx_q.size(); p0 = pulse_n;
    din_stuck = 1'b1;
    send_byte(8'h50); send_byte(8'h00); send_byte(8'h45); send_byte(8'h00); send_byte(8'h00);
    wait_tx(t0 + 2, "verify");
    din_stuck = 1'b0;
    check("verify NAK", tx_q[t0], 8'h15);
    check("verify fail addr", tx_q[t0 + 1], 8'h45);
    check("verify pulse count", pulse_n - p0, 4);
    check("verify pulse addr", p_addr[p0 + 3], 11'h045);
    check("verify err", err, 1);
`endif

    check("vcc5 complement", vcc_bad, 0);
    check("addr/data stable in pulse", stab_bad, 0);
    check("no tx while tx_busy", txbusy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
